// File: rtl/spi_cfg_slave.sv
// SPI configuration slave (mode 0, 16-bit frames) for the synthesizer register
// bank. The SPI pins are oversampled on sclk; nothing is clocked by spi_clk.
// Frame: {W, A[6:0], D[7:0]}, MSB first. Writes produce one wre pulse, and
// reads return rdata on spi_miso during the data byte.
`timescale 1ns/1ps
module spi_cfg_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       wre,
  output logic [7:0] addr,
  output logic [7:0] din,
  input  logic [7:0] rdata
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, csn_sync, mosi_sync;
  logic       clk_prev;
  logic       clk_s, csn_s, mosi_s;
  logic       rise, fall;
  logic       armed;
  logic [4:0] bit_cnt;
  logic [6:0] cmd_sr;
  logic [6:0] din_sr;
  logic [7:0] tx_sr;
  logic [7:0] cmd_nxt, din_nxt;
  logic       wr_flag;
  logic       load_pend;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign csn_s   = csn_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = clk_s & ~clk_prev;
  assign fall    = ~clk_s & clk_prev;
  // Full byte including the bit arriving on the current rise.
  assign cmd_nxt = {cmd_sr, mosi_s};
  assign din_nxt = {din_sr, mosi_s};

  // Synchronize the asynchronous SPI pins and keep one extra clock sample for edge detection.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      clk_sync  <= '0;
      csn_sync  <= '0;
      mosi_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      clk_prev  <= clk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a high csn in CMD or DATA aborts the frame and takes priority over edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!csn_s && armed) state_nxt = CMD;
      CMD: begin
        if (csn_s)                          state_nxt = IDLE;
        else if (rise && bit_cnt == 5'd7)   state_nxt = DATA;
      end
      DATA: begin
        if (csn_s)                          state_nxt = IDLE;
        else if (rise && bit_cnt == 5'd15)  state_nxt = DONE;
      end
      DONE: if (csn_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter, register-bank outputs and MISO.
  // armed stays low after reset until csn has been seen high, so a frame
  // interrupted by reset is ignored until csn is released.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      armed     <= 1'b0;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      din_sr    <= '0;
      tx_sr     <= '0;
      wr_flag   <= 1'b0;
      load_pend <= 1'b0;
      addr      <= '0;
      din       <= '0;
      wre       <= 1'b0;
      spi_miso  <= 1'b0;
    end else begin
      armed     <= armed | csn_s;
      wre       <= 1'b0;
      load_pend <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          cmd_sr  <= '0;
          din_sr  <= '0;
        end
        CMD: begin
          if (csn_s) begin
            bit_cnt <= '0;
          end else if (rise) begin
            cmd_sr  <= cmd_nxt[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              addr      <= {1'b0, cmd_nxt[6:0]};
              wr_flag   <= cmd_nxt[7];
              load_pend <= 1'b1;
            end
          end
        end
        DATA: begin
          if (csn_s) begin
            bit_cnt <= '0;
          end else if (rise) begin
            din_sr  <= din_nxt[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15 && wr_flag) begin
              din <= din_nxt;
              wre <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Read data is captured one cycle after addr settles, then shifted out on falls of bits 9..15.
      if (load_pend)
        tx_sr <= rdata;
      else if (state == DATA && fall && bit_cnt >= 5'd9 && bit_cnt <= 5'd15)
        tx_sr <= {tx_sr[6:0], 1'b0};
      spi_miso <= (state == DATA) ? tx_sr[7] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Scoreboard bench for spi_cfg_slave: directed SPI frames, with expected
// writes and read bytes queued by the stimulus and checked by monitors.
`timescale 1ns/1ps
module tb_spi_cfg_slave;

  localparam int HALF = 60;

  logic       sclk = 1'b0;
  logic       rstn;
  logic       spi_csn, spi_clk, spi_mosi;
  logic       spi_miso, wre;
  logic [7:0] addr, din, rdata;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 sclk = ~sclk;

  assign rdata = (addr == 8'h03) ? 8'hC3 : (addr ^ 8'h5A);

  spi_cfg_slave #(.SYNC_STAGES(2)) dut (
    .sclk(sclk), .rstn(rstn), .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .wre(wre), .addr(addr),
    .din(din), .rdata(rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every wre cycle must match the next queued write.
  always @(negedge sclk) begin
    if (wre === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wre actual addr=%0h din=%0h required no wre", addr, din);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wre_addr", {24'd0, addr}, {24'd0, e.a});
        chk("wre_din", {24'd0, din}, {24'd0, e.d});
      end
    end
  end

  // Read monitor: acts as the SPI master's receiver and checks the MISO byte of full read frames.
  initial begin : rd_mon
    int          cnt;
    logic [15:0] fr;
    logic [7:0]  mb;
    forever begin
      @(negedge spi_csn);
      cnt = 0; fr = '0; mb = '0;
      forever begin
        @(posedge spi_clk or posedge spi_csn);
        if (spi_csn) break;
        if (cnt < 16) fr = {fr[14:0], spi_mosi};
        if (cnt >= 8 && cnt < 16) mb = {mb[6:0], spi_miso};
        cnt++;
      end
      if (cnt >= 16 && !fr[15]) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read actual miso=%0h required no read", mb);
        end else begin
          chk("read_miso", {24'd0, mb}, {24'd0, rd_q.pop_front()});
        end
      end
    end
  end

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    #HALF spi_clk = 1'b1;
    #HALF spi_clk = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nclk, input int gap);
    spi_csn = 1'b0;
    #HALF;
    for (int i = 0; i < nclk; i++) spi_bit((i < 16) ? f[15-i] : 1'b0);
    spi_mosi = 1'b0;
    #HALF spi_csn = 1'b1;
    #gap;
  endtask

  task automatic write_frame(input logic [15:0] f, input int nclk, input int gap);
    wr_t e;
    e.a = {1'b0, f[14:8]};
    e.d = f[7:0];
    wr_q.push_back(e);
    spi_frame(f, nclk, gap);
    chk("wr_drained", wr_q.size(), 0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] rf;
    rstn = 1'b0; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge sclk);
    rstn = 1'b1;
    repeat (5) @(negedge sclk);
    chk("reset_wre", {31'd0, wre}, 0);
    chk("reset_addr", {24'd0, addr}, 0);
    chk("reset_din", {24'd0, din}, 0);
    chk("reset_miso", {31'd0, spi_miso}, 0);

    write_frame(16'h8A5C, 16, 200);

    rd_q.push_back(8'hC3);
    spi_frame(16'h0300, 16, 200);
    chk("read_drained", rd_q.size(), 0);
    chk("read_din_kept", {24'd0, din}, 32'h5C);

    spi_frame(16'h81FF, 12, 200);
    chk("abort_din_kept", {24'd0, din}, 32'h5C);
    chk("abort_addr", {24'd0, addr}, 32'h01);
    write_frame(16'h8122, 16, 200);

    write_frame(16'h8D3F, 20, 200);

    rf = 16'h8099;
    spi_csn = 1'b0;
    #HALF;
    for (int i = 0; i < 10; i++) spi_bit(rf[15-i]);
    rstn = 1'b0;
    #1;
    chk("midrst_wre", {31'd0, wre}, 0);
    chk("midrst_addr", {24'd0, addr}, 0);
    chk("midrst_din", {24'd0, din}, 0);
    chk("midrst_miso", {31'd0, spi_miso}, 0);
    #9;
    for (int i = 10; i < 12; i++) spi_bit(rf[15-i]);
    rstn = 1'b1;
    for (int i = 12; i < 16; i++) spi_bit(rf[15-i]);
    spi_mosi = 1'b0;
    #HALF spi_csn = 1'b1;
    #200;
    chk("midrst_din_after", {24'd0, din}, 0);
    write_frame(16'h8011, 16, 200);

    write_frame(16'h8001, 16, 40);
    write_frame(16'h8102, 16, 200);

    #200;
    chk("final_wr_q_empty", wr_q.size(), 0);
    chk("final_rd_q_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
